// File: rtl/traffic_pkg.sv
// Shared types and constants for the four-way traffic-light controller.
package traffic_pkg;

  // Phase states of the intersection controller.
  typedef enum logic [3:0] {
    st_idle,
    st_ns_left,
    st_ns_green,
    st_ns_yellow,
    st_ns_allred,
    st_ew_left,
    st_ew_green,
    st_ew_yellow,
    st_ew_allred
  } state_t;

  // Car nibble codes, bit order {left arrow, green, yellow, red}.
  localparam logic [3:0] car_red    = 4'b0001;
  localparam logic [3:0] car_left   = 4'b1001;
  localparam logic [3:0] car_green  = 4'b0100;
  localparam logic [3:0] car_yellow = 4'b0010;

  // Crosswalk codes, bit order {walk, dont_walk}.
  localparam logic [1:0] walk_on   = 2'b10;
  localparam logic [1:0] walk_stop = 2'b01;

  // Default phase durations in clock cycles.
  localparam int unsigned def_left_cyc   = 8;
  localparam int unsigned def_green_cyc  = 20;
  localparam int unsigned def_yellow_cyc = 5;
  localparam int unsigned def_allred_cyc = 2;

endpackage

// File: rtl/traffic_phase_timer.sv
// 8-bit phase counter: cleared on reset or clear, otherwise counts up;
// done flags the cycle in which the count reaches the terminal value.
module phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] term,
  output logic       done
);

  logic [7:0] count;

  // Count cycles within the current phase; restart on every phase change.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else begin
      count <= count + 8'd1;
    end
  end

  assign done = (count == term);

endmodule

// File: rtl/traffic_top.sv
// Four-way intersection controller: cycles NS then EW through
// left / green / yellow / all-red, with crosswalks walking on green.
// All lights are decoded from the registered phase state only.
module traffic_top
  import traffic_pkg::*;
#(
  parameter int unsigned LEFT_CYC   = def_left_cyc,
  parameter int unsigned GREEN_CYC  = def_green_cyc,
  parameter int unsigned YELLOW_CYC = def_yellow_cyc,
  parameter int unsigned ALLRED_CYC = def_allred_cyc
) (
  input  logic        clk,
  input  logic        reset_n,   // active-high synchronous reset despite the name
  input  logic        i_start,
  output logic [15:0] o_ct,
  output logic [7:0]  o_wt
);

  // A phase ends in the cycle where the counter equals duration - 1.
  localparam logic [7:0] left_term   = 8'(LEFT_CYC - 1);
  localparam logic [7:0] green_term  = 8'(GREEN_CYC - 1);
  localparam logic [7:0] yellow_term = 8'(YELLOW_CYC - 1);
  localparam logic [7:0] allred_term = 8'(ALLRED_CYC - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] term;
  logic       done;
  logic       clear;

  // Hold the counter at zero in idle and restart it on every phase change.
  assign clear = (state_next != state) || (state == st_idle);

  phase_timer u_timer (
    .clk   (clk),
    .rst   (reset_n),
    .clear (clear),
    .term  (term),
    .done  (done)
  );

  // Phase state register; reset always returns to idle.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= st_idle;
    end else begin
      state <= state_next;
    end
  end

  // Select the terminal count for the phase being timed.
  always_comb begin
    term = 8'd0;
    case (state)
      st_ns_left,   st_ew_left:   term = left_term;
      st_ns_green,  st_ew_green:  term = green_term;
      st_ns_yellow, st_ew_yellow: term = yellow_term;
      st_ns_allred, st_ew_allred: term = allred_term;
      default:                    term = 8'd0;
    endcase
  end

  // Next-phase logic: start is only looked at in idle; afterwards loop forever.
  always_comb begin
    state_next = state;
    case (state)
      st_idle:      if (i_start) state_next = st_ns_left;
      st_ns_left:   if (done)    state_next = st_ns_green;
      st_ns_green:  if (done)    state_next = st_ns_yellow;
      st_ns_yellow: if (done)    state_next = st_ns_allred;
      st_ns_allred: if (done)    state_next = st_ew_left;
      st_ew_left:   if (done)    state_next = st_ew_green;
      st_ew_green:  if (done)    state_next = st_ew_yellow;
      st_ew_yellow: if (done)    state_next = st_ew_allred;
      st_ew_allred: if (done)    state_next = st_ns_left;
      default:                   state_next = st_idle;
    endcase
  end

  logic [3:0] car_ns;
  logic [3:0] car_ew;
  logic [1:0] walk_ns;
  logic [1:0] walk_ew;

  // Decode lights from state; anything not named shows red / stop.
  always_comb begin
    car_ns  = car_red;
    car_ew  = car_red;
    walk_ns = walk_stop;
    walk_ew = walk_stop;
    case (state)
      st_ns_left:   car_ns = car_left;
      st_ns_green:  begin car_ns = car_green; walk_ns = walk_on; end
      st_ns_yellow: car_ns = car_yellow;
      st_ew_left:   car_ew = car_left;
      st_ew_green:  begin car_ew = car_green; walk_ew = walk_on; end
      st_ew_yellow: car_ew = car_yellow;
      default:      ;
    endcase
  end

  assign o_ct = {car_ns, car_ew, car_ns, car_ew};
  assign o_wt = {walk_ns, walk_ew, walk_ns, walk_ew};

endmodule

// File: tb/tb_traffic_top.sv
// Directed bench for traffic_top: default timing instance plus a
// one-cycle-per-phase instance, checked against the published schedule.
module tb_traffic_top;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [15:0] o_ct;
  logic [7:0]  o_wt;

  logic        fast_reset;
  logic        fast_start;
  logic [15:0] fast_ct;
  logic [7:0]  fast_wt;

  int checks;
  int failures;

  traffic_top dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (i_start),
    .o_ct    (o_ct),
    .o_wt    (o_wt)
  );

  traffic_top #(
    .LEFT_CYC   (1),
    .GREEN_CYC  (1),
    .YELLOW_CYC (1),
    .ALLRED_CYC (1)
  ) dut_fast (
    .clk     (clk),
    .reset_n (fast_reset),
    .i_start (fast_start),
    .o_ct    (fast_ct),
    .o_wt    (fast_wt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected car lights at cycle t of the default 70-cycle schedule.
  function automatic logic [15:0] sched_ct(input int t);
    int m;
    m = t % 70;
    if (m < 8)       return 16'h9191;
    else if (m < 28) return 16'h4141;
    else if (m < 33) return 16'h2121;
    else if (m < 35) return 16'h1111;
    else if (m < 43) return 16'h1919;
    else if (m < 63) return 16'h1414;
    else if (m < 68) return 16'h1212;
    else             return 16'h1111;
  endfunction

  function automatic logic [7:0] sched_wt(input int t);
    int m;
    m = t % 70;
    if (m >= 8 && m < 28)       return 8'h99;
    else if (m >= 43 && m < 63) return 8'h66;
    else                        return 8'h55;
  endfunction

  // Check the default instance over schedule cycles t_first..t_last;
  // the next falling edge is taken as cycle t_first.
  task automatic run_schedule(input string name, input int t_first, input int t_last);
    for (int t = t_first; t <= t_last; t++) begin
      @(negedge clk);
      checks++;
      if (o_ct !== sched_ct(t)) begin
        failures++;
        $display("FAIL %s_ct t=%0d got=%h exp=%h", name, t, o_ct, sched_ct(t));
      end
      checks++;
      if (o_wt !== sched_wt(t)) begin
        failures++;
        $display("FAIL %s_wt t=%0d got=%h exp=%h", name, t, o_wt, sched_wt(t));
      end
    end
  endtask

  task automatic expect_idle(input string name);
    checks++;
    if (o_ct !== 16'h1111) begin
      failures++;
      $display("FAIL %s_ct got=%h exp=1111", name, o_ct);
    end
    checks++;
    if (o_wt !== 8'h55) begin
      failures++;
      $display("FAIL %s_wt got=%h exp=55", name, o_wt);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    i_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_idle("reset_hold");
    end
  endtask

  task automatic test_main_cycle();
    // Release reset between edges: the IDLE cycle is visible before the next edge.
    reset_n = 1'b0;
    expect_idle("release_idle");
    run_schedule("main", 0, 70);
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    run_schedule("pre_mid", 0, 20);
    reset_n = 1'b1;
    @(negedge clk);
    expect_idle("mid_reset");
    reset_n = 1'b0;
    run_schedule("post_mid", 0, 70);
  endtask

  task automatic test_start_idle();
    reset_n = 1'b1;
    i_start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_idle("no_start");
    end
    i_start = 1'b1;
    run_schedule("raise_start", 0, 0);
    i_start = 1'b0;
    run_schedule("drop_start", 1, 75);
  endtask

  task automatic test_reset_wins();
    reset_n = 1'b1;
    i_start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    expect_idle("wins_pre");
    reset_n = 1'b1;
    i_start = 1'b1;
    @(negedge clk);
    expect_idle("reset_wins");
    reset_n = 1'b0;
    run_schedule("after_wins", 0, 2);
  endtask

  task automatic test_fast();
    logic [15:0] exp_ct [8];
    logic [7:0]  exp_wt [8];
    exp_ct = '{16'h9191, 16'h4141, 16'h2121, 16'h1111,
               16'h1919, 16'h1414, 16'h1212, 16'h1111};
    exp_wt = '{8'h55, 8'h99, 8'h55, 8'h55, 8'h55, 8'h66, 8'h55, 8'h55};
    fast_reset = 1'b0;
    checks++;
    if (fast_ct !== 16'h1111) begin
      failures++;
      $display("FAIL fast_idle got=%h exp=1111", fast_ct);
    end
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      checks++;
      if (fast_ct !== exp_ct[t % 8]) begin
        failures++;
        $display("FAIL fast_ct t=%0d got=%h exp=%h", t, fast_ct, exp_ct[t % 8]);
      end
      checks++;
      if (fast_wt !== exp_wt[t % 8]) begin
        failures++;
        $display("FAIL fast_wt t=%0d got=%h exp=%h", t, fast_wt, exp_wt[t % 8]);
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b1;
    i_start    = 1'b1;
    fast_reset = 1'b1;
    fast_start = 1'b1;
    test_reset();
    test_main_cycle();
    test_reset_mid();
    test_start_idle();
    test_reset_wins();
    test_fast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_top.md
# traffic_top

Four-way intersection traffic-light controller that sequences protected-left, through-green, yellow and all-red phases for the north-south (NS) and east-west (EW) axes. It also drives the four pedestrian crosswalk signals. It is the top-level block of the traffic-light design and is driven by one clock and a start level from the board. All outputs are decoded from a registered phase state machine.

## Interface
- LEFT_CYC, default 8: protected-left phase length in clock cycles (1..256).
- GREEN_CYC, default 20: through-green phase length (1..256).
- YELLOW_CYC, default 5: yellow phase length (1..256).
- ALLRED_CYC, default 2: all-red clearance length (1..256).
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-high reset; the name is kept for board compatibility.
- i_start  in  1  level; while idle, 1 starts the light cycle.
- o_ct  out  16  car lights, 4 bits per approach: [15:12] N, [11:8] E, [7:4] S, [3:0] W.
  - Bit order within each nibble: {left arrow, green, yellow, red}.
- o_wt  out  8  walk lights, 2 bits per crosswalk: [7:6] N, [5:4] E, [3:2] S, [1:0] W.
  - Bit order within each pair: {walk, dont_walk}.

## Operation
- Car nibble codes: RED = 0001, LEFT = 1001 (left arrow with red), GREEN = 0100, YELLOW = 0010.
- Walk codes: WALK = 10, STOP = 01. Each approach and each crosswalk always shows exactly one code.
- States and outputs. Unlisted approaches show RED; unlisted crosswalks show STOP.
  - IDLE: all approaches RED, all crosswalks STOP.
  - NS_LEFT: N and S show LEFT.
  - NS_GREEN: N and S show GREEN; crosswalks N and S show WALK.
  - NS_YELLOW: N and S show YELLOW.
  - NS_ALLRED: all approaches RED.
  - EW_LEFT, EW_GREEN, EW_YELLOW, EW_ALLRED: same as the NS states, applied to E and W.
- Transitions:
  - IDLE goes to NS_LEFT when i_start = 1.
  - NS_LEFT → NS_GREEN → NS_YELLOW → NS_ALLRED → EW_LEFT → EW_GREEN → EW_YELLOW → EW_ALLRED → NS_LEFT, looping forever.
- i_start is sampled only in IDLE. Deasserting it while running has no effect; only reset stops the cycle.
- Phase counter: 8-bit, cleared on every state change. A timed state advances at the edge where the counter equals its duration − 1, so each state lasts exactly its parameter in cycles. The counter never wraps because durations are ≤ 256.
- Reset, at any time including mid-phase: state = IDLE and counter = 0 at that edge. Outputs read all RED, all STOP (o_ct = 16'h1111, o_wt = 8'h55).

## Timing
- Outputs are combinational decodes of the state register only. No input reaches an output combinationally.
- Start latency: if i_start is high at the edge after reset deasserts, NS_LEFT outputs appear after that edge, i.e. one cycle of IDLE.
- With the default parameters the full cycle is 70 cycles (700 ns at 100 MHz).
- Default schedule, with t = 0 as the first NS_LEFT cycle:
  - NS_LEFT t0–7, NS_GREEN t8–27, NS_YELLOW t28–32, NS_ALLRED t33–34.
  - EW_LEFT t35–42, EW_GREEN t43–62, EW_YELLOW t63–67, EW_ALLRED t68–69.
  - NS_LEFT again at t70.
- A reset asserted during the same cycle as i_start wins: the block stays in IDLE.

## Structure
- Package traffic_pkg holds:
  - the state enum (9 states);
  - the car nibble constants RED/LEFT/GREEN/YELLOW;
  - the walk constants WALK/STOP;
  - the default duration constants.
- One sub-module, phase_timer: the 8-bit counter with a load/clear input and a terminal-count output. The FSM and output decode stay in top.

## Test plan
- Reset held high with i_start = 1 → o_ct = 16'h1111, o_wt = 8'h55 on every cycle.
- Release reset with i_start = 1 → one IDLE cycle, then o_ct = 16'h9191 for 8 cycles, then 16'h4141 for 20 cycles with o_wt = 8'h99.
- Continue the same run:
  - t28–32: o_ct = 16'h2121;
  - t33–34: 16'h1111;
  - t35: 16'h1919;
  - t43: 16'h1414 with o_wt = 8'h66;
  - t70: 16'h9191 again.
- Reset pulsed for 1 cycle at t = 20 (during NS_GREEN) → next cycle all RED/STOP. With i_start still high, NS_LEFT resumes one cycle after release and the full 70-cycle schedule repeats.
- i_start = 0 after reset → stays IDLE indefinitely. Raising i_start enters NS_LEFT at the next edge. Dropping i_start mid-cycle changes nothing.
- Parameters LEFT_CYC = 1, GREEN_CYC = 1, YELLOW_CYC = 1, ALLRED_CYC = 1 → each state lasts exactly one cycle, with an 8-cycle period.
